// File: rtl/aes_v2_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle aes_v2 unit
// between NREQ requesters with a valid/ready response return path.
module aes_v2_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 8
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_sub,
    input  logic [NREQ-1:0]   req_enc,
    input  logic [NREQ-1:0]   req_rot,
    input  logic [32*NREQ-1:0] req_rs1,
    input  logic [32*NREQ-1:0] req_rs2,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              aes_valid,
    output logic              aes_sub,
    output logic              aes_enc,
    output logic              aes_rot,
    output logic [31:0]       aes_rs1,
    output logic [31:0]       aes_rs2,
    input  logic              aes_ready,
    input  logic [31:0]       aes_rd
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] owner;
    logic [IW-1:0] grant;
    logic [IW-1:0] ptr_nxt;
    logic [IW:0]   cand;
    logic [TW-1:0] tmo_cnt;
    logic          found;
    logic          accept;
    logic          tmo_hit;

    // Search upward from rr_ptr with wrap for the first valid requester.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ))
                cand = cand - (IW+1)'(NREQ);
            if (!found && req_valid[cand[IW-1:0]]) begin
                found = 1'b1;
                grant = cand[IW-1:0];
            end
        end
    end

    assign accept  = (state == IDLE) && found && g_resetn;
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));
    assign ptr_nxt = (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && (grant == IW'(i));
            rsp_valid[i] = (state == RESP) && (owner == IW'(i));
        end
    end

    assign aes_valid = (state == LAUNCH);

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (accept) state_nxt = LAUNCH;
            LAUNCH: state_nxt = WAIT;
            WAIT:   if (aes_ready || tmo_hit) state_nxt = RESP;
            RESP:   if (rsp_ready[owner]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands stay registered and driven until the next accept.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rr_ptr   <= '0;
            owner    <= '0;
            tmo_cnt  <= '0;
            aes_sub  <= 1'b0;
            aes_enc  <= 1'b0;
            aes_rot  <= 1'b0;
            aes_rs1  <= '0;
            aes_rs2  <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        owner   <= grant;
                        rr_ptr  <= ptr_nxt;
                        aes_sub <= req_sub[grant];
                        aes_enc <= req_enc[grant];
                        aes_rot <= req_rot[grant];
                        aes_rs1 <= req_rs1[32*grant +: 32];
                        aes_rs2 <= req_rs2[32*grant +: 32];
                    end
                end
                LAUNCH: tmo_cnt <= '0;
                WAIT: begin
                    if (tmo_cnt != '1)
                        tmo_cnt <= tmo_cnt + 1'b1;
                    if (aes_ready) begin
                        rsp_data <= aes_rd;
                        rsp_err  <= 1'b0;
                    end else if (tmo_hit) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                RESP: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_v2_arbiter.sv
// Randomized bench for aes_v2_arbiter: transaction-level model plus a
// stub aes_v2 unit with random latency, stray ready pulses and resets.
module tb_aes_v2_arbiter;

    localparam int NREQ = 2;
    localparam int T    = 8;
    localparam int NCYC = 3000;
    localparam int BIG  = 32'h3fff_ffff;

    logic                 g_clk = 1'b0;
    logic                 g_resetn;
    logic [NREQ-1:0]      req_valid, req_ready, req_sub, req_enc, req_rot;
    logic [NREQ-1:0]      rsp_valid, rsp_ready;
    logic [32*NREQ-1:0]   req_rs1, req_rs2;
    logic [31:0]          rsp_data, aes_rs1, aes_rs2, aes_rd;
    logic                 rsp_err, aes_valid, aes_sub, aes_enc, aes_rot;
    logic                 aes_ready;

    aes_v2_arbiter #(.NREQ(NREQ), .TIMEOUT(T)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sub(req_sub), .req_enc(req_enc), .req_rot(req_rot),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .aes_valid(aes_valid), .aes_sub(aes_sub), .aes_enc(aes_enc),
        .aes_rot(aes_rot), .aes_rs1(aes_rs1), .aes_rs2(aes_rs2),
        .aes_ready(aes_ready), .aes_rd(aes_rd)
    );

    always #5 g_clk = ~g_clk;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [71:0] got,
                       input logic [71:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stand-in for the shared unit's function: any injective-ish mix will do.
    function automatic logic [31:0] fx(input logic s, input logic e,
                                       input logic r, input logic [31:0] a,
                                       input logic [31:0] b);
        return a ^ {b[15:0], b[31:16]} ^ {29'd0, s, e, r};
    endfunction

    bit          pend [NREQ];
    logic        p_sub [NREQ];
    logic        p_enc [NREQ];
    logic        p_rot [NREQ];
    logic [31:0] p_rs1 [NREQ];
    logic [31:0] p_rs2 [NREQ];

    bit          busy;
    int          ptr, own, acc, rsp_at, lat, hold, nrst;
    logic [66:0] m_ops;
    logic [32:0] m_res;

    task automatic drive(input int c);
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(9) < 4) begin
                pend[i]  = 1'b1;
                p_sub[i] = 1'($urandom_range(1));
                p_enc[i] = 1'($urandom_range(1));
                p_rot[i] = 1'($urandom_range(1));
                p_rs1[i] = $urandom;
                p_rs2[i] = $urandom;
            end
            req_valid[i]         = pend[i];
            req_sub[i]           = p_sub[i];
            req_enc[i]           = p_enc[i];
            req_rot[i]           = p_rot[i];
            req_rs1[32*i +: 32]  = p_rs1[i];
            req_rs2[32*i +: 32]  = p_rs2[i];
        end
        aes_ready = 1'b0;
        aes_rd    = $urandom;
        if (busy && c >= acc + 2 && c < rsp_at) begin
            if (c == acc + 1 + lat) begin
                aes_ready = 1'b1;
                aes_rd = fx(aes_sub, aes_enc, aes_rot, aes_rs1, aes_rs2);
            end
        end else if ($urandom_range(15) == 0) begin
            aes_ready = 1'b1;
        end
        rsp_ready = NREQ'($urandom);
        if (busy)
            rsp_ready[own] = (c >= rsp_at + hold);
    endtask

    task automatic check(input int c, output int g);
        logic [NREQ-1:0] e;
        g = -1;
        if (!busy)
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (ptr + k) % NREQ;
                if (g < 0 && pend[j]) g = j;
            end
        e = '0;
        if (g >= 0) e[g] = 1'b1;
        chk("req_ready", 72'(req_ready), 72'(e));
        chk("aes_valid", 72'(aes_valid), 72'(busy && c == acc + 1));
        e = '0;
        if (busy && c >= rsp_at) e[own] = 1'b1;
        chk("rsp_valid", 72'(rsp_valid), 72'(e));
        if (busy && c >= acc + 1)
            chk("aes_ops", 72'({aes_sub, aes_enc, aes_rot, aes_rs1, aes_rs2}),
                72'(m_ops));
        if (busy && c >= rsp_at)
            chk("rsp_data", 72'({rsp_err, rsp_data}), 72'(m_res));
    endtask

    task automatic update(input int c, input int g);
        if (!busy) begin
            if (g >= 0) begin
                busy   = 1'b1;
                acc    = c;
                own    = g;
                m_ops  = {p_sub[g], p_enc[g], p_rot[g], p_rs1[g], p_rs2[g]};
                ptr    = (g + 1) % NREQ;
                rsp_at = BIG;
                lat    = ($urandom_range(9) < 7) ? 3 : int'($urandom_range(T + 2, 1));
                hold   = ($urandom_range(3) == 0) ? int'($urandom_range(12)) : 0;
                pend[g]  = 1'b0;
                p_rs1[g] = $urandom;
            end
        end else if (c >= acc + 2 && c < rsp_at) begin
            if (aes_ready) begin
                rsp_at = c + 1;
                m_res  = {1'b0, fx(m_ops[66], m_ops[65], m_ops[64],
                                   m_ops[63:32], m_ops[31:0])};
            end else if (c == acc + 1 + T) begin
                rsp_at = c + 1;
                m_res  = {1'b1, 32'd0};
            end
        end else if (c >= rsp_at && rsp_ready[own]) begin
            busy = 1'b0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 72'({req_ready, rsp_valid, aes_valid, aes_sub,
                                aes_enc, aes_rot, rsp_err}), 72'(0));
        chk({tag, "_ops"}, 72'({aes_rs1, aes_rs2}), 72'(0));
        chk({tag, "_dat"}, 72'(rsp_data), 72'(0));
    endtask

    task automatic mid_reset();
        g_resetn = 1'b0;
        #1;
        chk_zero("mid_reset");
        busy = 1'b0;
        ptr  = 0;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        req_valid = '0;
        aes_ready = 1'b0;
        rsp_ready = '0;
        @(posedge g_clk);
        #2 g_resetn = 1'b1;
        nrst++;
    endtask

    initial begin
        int g;
        g_resetn  = 1'b0;
        req_valid = '0;
        req_sub   = '0;
        req_enc   = '0;
        req_rot   = '0;
        req_rs1   = '0;
        req_rs2   = '0;
        rsp_ready = '0;
        aes_ready = 1'b0;
        aes_rd    = '0;
        busy = 1'b0;
        ptr  = 0;
        own  = 0;
        acc  = -10;
        rsp_at = BIG;
        lat  = 3;
        hold = 0;
        nrst = 0;
        m_ops = '0;
        m_res = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i]  = 1'b0;
            p_sub[i] = 1'b0;
            p_enc[i] = 1'b0;
            p_rot[i] = 1'b0;
            p_rs1[i] = '0;
            p_rs2[i] = '0;
        end
        pend[0]  = 1'b1;
        p_sub[0] = 1'b1;
        p_enc[0] = 1'b1;
        p_rs1[0] = 32'h0000_0053;
        #3;
        chk_zero("reset");
        repeat (2) @(posedge g_clk);
        #2 g_resetn = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge g_clk);
            #1;
            drive(c);
            #4;
            check(c, g);
            if (busy && c == acc + 3 && c < rsp_at && nrst < 2
                && c > 400 * (nrst + 1)) begin
                mid_reset();
                continue;
            end
            update(c, g);
        end
        if (nrst == 0) begin
            @(posedge g_clk);
            #1;
            mid_reset();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
